// File: rtl/cmul_pkg.sv
// rtl/cmul_pkg.sv - shared encodings and constants for the sequential complex multiplier
package cmul_pkg;

    localparam int DW       = 32;
    localparam int SIGN_BIT = 31;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Slot order is also the order the multiplier is fed in MUL.
    localparam logic [1:0] RR = 2'd0;
    localparam logic [1:0] II = 2'd1;
    localparam logic [1:0] RI = 2'd2;
    localparam logic [1:0] IR = 2'd3;

endpackage

// File: rtl/cplx_mul_seq_if.sv
// rtl/cplx_mul_seq_if.sv - operand/product handshake bundle of the complex multiply stage
interface cplx_mul_seq_if;

    logic                    in_valid;
    logic                    in_ready;
    logic [cmul_pkg::DW-1:0] a_re;
    logic [cmul_pkg::DW-1:0] a_im;
    logic [cmul_pkg::DW-1:0] b_re;
    logic [cmul_pkg::DW-1:0] b_im;
    logic                    out_valid;
    logic                    out_ready;
    logic [cmul_pkg::DW-1:0] p_rr;
    logic [cmul_pkg::DW-1:0] p_ii;
    logic [cmul_pkg::DW-1:0] p_ri;
    logic [cmul_pkg::DW-1:0] p_ir;
    logic                    busy;

    modport master (
        output in_valid, a_re, a_im, b_re, b_im, out_ready,
        input  in_ready, out_valid, p_rr, p_ii, p_ri, p_ir, busy
    );

    modport slave (
        input  in_valid, a_re, a_im, b_re, b_im, out_ready,
        output in_ready, out_valid, p_rr, p_ii, p_ri, p_ir, busy
    );

endinterface

// File: rtl/cplx_mul_seq_mul.sv
// rtl/cplx_mul_seq_mul.sv - combinational float32 multiplier, round-to-nearest-even
// Inf/NaN operands give 0, zero/denormal operands and underflow give signed zero, overflow gives signed Inf.
module multiplication (
    input  logic [31:0] a_operand,
    input  logic [31:0] b_operand,
    output logic [31:0] result
);

    logic              sign;
    logic [7:0]        ea;
    logic [7:0]        eb;
    logic [47:0]       prod;
    logic [22:0]       frac;
    logic              guard;
    logic              sticky;
    logic              round_up;
    logic [23:0]       frac_r;
    logic signed [9:0] exp_n;
    logic signed [9:0] exp_r;

    always_comb begin
        sign = a_operand[31] ^ b_operand[31];
        ea   = a_operand[30:23];
        eb   = b_operand[30:23];
        prod = 48'({1'b1, a_operand[22:0]}) * 48'({1'b1, b_operand[22:0]});

        // Product of two 1.x mantissas lies in [1,4); bit 47 says which binade.
        if (prod[47]) begin
            frac   = prod[46:24];
            guard  = prod[23];
            sticky = |prod[22:0];
            exp_n  = $signed({2'b00, ea}) + $signed({2'b00, eb}) - 10'sd126;
        end else begin
            frac   = prod[45:23];
            guard  = prod[22];
            sticky = |prod[21:0];
            exp_n  = $signed({2'b00, ea}) + $signed({2'b00, eb}) - 10'sd127;
        end

        round_up = guard & (sticky | frac[0]);
        frac_r   = {1'b0, frac} + {23'd0, round_up};
        exp_r    = exp_n + $signed({9'd0, frac_r[23]});

        if ((&ea) || (&eb)) begin
            result = 32'h0;
        end else if (ea == 8'd0 || eb == 8'd0) begin
            result = {sign, 31'd0};
        end else if (exp_r >= 10'sd255) begin
            result = {sign, 8'hFF, 23'd0};
        end else if (exp_r <= 10'sd0) begin
            result = {sign, 31'd0};
        end else begin
            result = {sign, exp_r[7:0], frac_r[22:0]};
        end
    end

endmodule

// File: rtl/cplx_mul_seq.sv
// rtl/cplx_mul_seq.sv - complex operand stage sharing one float32 multiplier over four partial products
// Optional CMUL_NEG_EN: the a_im*b_im product is sign-inverted so downstream only adds.
module cplx_mul_seq #(
    parameter int DW    = 32,
    parameter int IDX_W = 2
) (
    input  logic                clk,
    input  logic                rst,
    cplx_mul_seq_if.slave       bus
);

    cmul_pkg::state_e   state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               in_ready_q, in_ready_d;
    logic               out_valid_q, out_valid_d;
    logic               busy_q, busy_d;
    logic [DW-1:0]      a_re_q, a_re_d;
    logic [DW-1:0]      a_im_q, a_im_d;
    logic [DW-1:0]      b_re_q, b_re_d;
    logic [DW-1:0]      b_im_q, b_im_d;
    logic [DW-1:0]      p_q [4];
    logic [DW-1:0]      p_d [4];

    logic [DW-1:0]      mul_a;
    logic [DW-1:0]      mul_b;
    logic [DW-1:0]      mul_res;
    logic [DW-1:0]      slot_val;

    always_comb begin
        mul_a = a_re_q;
        mul_b = b_re_q;
        case (idx_q)
            cmul_pkg::RR: begin mul_a = a_re_q; mul_b = b_re_q; end
            cmul_pkg::II: begin mul_a = a_im_q; mul_b = b_im_q; end
            cmul_pkg::RI: begin mul_a = a_re_q; mul_b = b_im_q; end
            default:      begin mul_a = a_im_q; mul_b = b_re_q; end
        endcase
    end

    multiplication u_mul (
        .a_operand (mul_a),
        .b_operand (mul_b),
        .result    (mul_res)
    );

    always_comb begin
        slot_val = mul_res;
`ifdef CMUL_NEG_EN
        if (idx_q == cmul_pkg::II) begin
            slot_val[cmul_pkg::SIGN_BIT] = ~mul_res[cmul_pkg::SIGN_BIT];
        end
`endif
    end

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        busy_d      = busy_q;
        a_re_d      = a_re_q;
        a_im_d      = a_im_q;
        b_re_d      = b_re_q;
        b_im_d      = b_im_q;
        for (int i = 0; i < 4; i++) begin
            p_d[i] = p_q[i];
        end

        case (state_q)
            cmul_pkg::IDLE: begin
                if (bus.in_valid && in_ready_q) begin
                    state_d    = cmul_pkg::MUL;
                    idx_d      = '0;
                    in_ready_d = 1'b0;
                    busy_d     = 1'b1;
                    a_re_d     = bus.a_re;
                    a_im_d     = bus.a_im;
                    b_re_d     = bus.b_re;
                    b_im_d     = bus.b_im;
                end
            end
            cmul_pkg::MUL: begin
                p_d[idx_q] = slot_val;
                // Natural wrap takes the counter back to 0 as the last slot is written.
                idx_d      = idx_q + 1'b1;
                if (idx_q == {IDX_W{1'b1}}) begin
                    state_d     = cmul_pkg::DONE;
                    out_valid_d = 1'b1;
                end
            end
            cmul_pkg::DONE: begin
                if (out_valid_q && bus.out_ready) begin
                    state_d     = cmul_pkg::IDLE;
                    out_valid_d = 1'b0;
                    busy_d      = 1'b0;
                    in_ready_d  = 1'b1;
                end
            end
            default: begin
                state_d     = cmul_pkg::IDLE;
                idx_d       = '0;
                in_ready_d  = 1'b1;
                out_valid_d = 1'b0;
                busy_d      = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= cmul_pkg::IDLE;
            idx_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            a_re_q      <= '0;
            a_im_q      <= '0;
            b_re_q      <= '0;
            b_im_q      <= '0;
            for (int i = 0; i < 4; i++) begin
                p_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            a_re_q      <= a_re_d;
            a_im_q      <= a_im_d;
            b_re_q      <= b_re_d;
            b_im_q      <= b_im_d;
            for (int i = 0; i < 4; i++) begin
                p_q[i] <= p_d[i];
            end
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.busy      = busy_q;
    assign bus.p_rr      = p_q[cmul_pkg::RR];
    assign bus.p_ii      = p_q[cmul_pkg::II];
    assign bus.p_ri      = p_q[cmul_pkg::RI];
    assign bus.p_ir      = p_q[cmul_pkg::IR];

endmodule

// File: tb/tb_cplx_mul_seq.sv
// tb/tb_cplx_mul_seq.sv - self-checking bench for cplx_mul_seq (honours CMUL_NEG_EN)
module tb_cplx_mul_seq;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    cplx_mul_seq_if bus ();

    cplx_mul_seq dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic [31:0] a_re, a_im, b_re, b_im;
        logic [31:0] p_rr, p_ii, p_ri, p_ir;
    } vec_t;

    vec_t tbl [6];
    vec_t exp_q [$];

    function automatic logic [31:0] neg_ii(logic [31:0] x);
`ifdef CMUL_NEG_EN
        return {~x[31], x[30:0]};
`else
        return x;
`endif
    endfunction

    function automatic real f2r(logic [31:0] f);
        logic [63:0] d;
        d = {f[31], 11'(int'(f[30:23]) + 896), f[22:0], 29'd0};
        return $bitstoreal(d);
    endfunction

    // Exact product in double precision, then rounded to float32 nearest-even.
    function automatic logic [31:0] fmul(logic [31:0] a, logic [31:0] b);
        logic        s;
        real         p;
        logic [63:0] d;
        int          fe;
        logic [23:0] man;
        logic        g;
        logic        st;
        s = a[31] ^ b[31];
        if (a[30:23] == 8'hFF || b[30:23] == 8'hFF) return 32'h0;
        if (a[30:23] == 8'h00 || b[30:23] == 8'h00) return {s, 31'd0};
        p   = f2r(a) * f2r(b);
        d   = $realtobits(p);
        fe  = int'(d[62:52]) - 1023 + 127;
        man = {1'b0, d[51:29]};
        g   = d[28];
        st  = |d[27:0];
        if (g && (st || man[0])) man = man + 24'd1;
        if (man[23]) begin
            fe  = fe + 1;
            man = 24'd0;
        end
        if (fe >= 255) return {s, 8'hFF, 23'd0};
        if (fe <= 0) return {s, 31'd0};
        return {s, 8'(fe), man[22:0]};
    endfunction

    function automatic vec_t model(logic [31:0] ar, logic [31:0] ai, logic [31:0] br, logic [31:0] bi);
        vec_t v;
        v.a_re = ar; v.a_im = ai; v.b_re = br; v.b_im = bi;
        v.p_rr = fmul(ar, br);
        v.p_ii = neg_ii(fmul(ai, bi));
        v.p_ri = fmul(ar, bi);
        v.p_ir = fmul(ai, br);
        return v;
    endfunction

    function automatic logic [31:0] rnd_f();
        int          r;
        logic [7:0]  e;
        r = $urandom_range(0, 15);
        if (r == 0)      e = 8'h00;
        else if (r == 1) e = 8'hFF;
        else if (r == 2) e = 8'($urandom_range(1, 20));
        else if (r == 3) e = 8'($urandom_range(235, 254));
        else             e = 8'($urandom_range(100, 154));
        return {1'($urandom), e, 23'($urandom)};
    endfunction

    task automatic check32(string name, logic [31:0] act, logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_int(string name, int act, int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_prod(string tag, vec_t v);
        check32({tag, " p_rr"}, bus.p_rr, v.p_rr);
        check32({tag, " p_ii"}, bus.p_ii, v.p_ii);
        check32({tag, " p_ri"}, bus.p_ri, v.p_ri);
        check32({tag, " p_ir"}, bus.p_ir, v.p_ir);
    endtask

    task automatic start_txn(vec_t v);
        int k;
        k = 0;
        while (!bus.in_ready && k < 20) begin
            tick();
            k++;
        end
        check_int("in_ready before start", int'(bus.in_ready), 1);
        bus.a_re = v.a_re; bus.a_im = v.a_im; bus.b_re = v.b_re; bus.b_im = v.b_im;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        bus.a_re = 32'hDEADBEEF; bus.a_im = 32'h12345678;
        bus.b_re = 32'h3F800000; bus.b_im = 32'hC0000000;
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        while (!bus.out_valid && lat < 20) begin
            tick();
            lat++;
        end
    endtask

    task automatic drain();
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        check_int("out_valid after accept", int'(bus.out_valid), 0);
        check_int("in_ready after accept", int'(bus.in_ready), 1);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int   lat;
        int   bcnt;
        int   n_acc;
        int   n_done;
        vec_t v;
        vec_t e;

        tbl[0] = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000,
                   32'h40400000, 32'h41000000, 32'h40800000, 32'h40C00000};
        tbl[1] = '{32'h7F800000, 32'h40000000, 32'h40400000, 32'h40800000,
                   32'h00000000, 32'h41000000, 32'h00000000, 32'h40C00000};
        tbl[2] = '{32'hBFC00000, 32'h00000000, 32'h40000000, 32'hBF000000,
                   32'hC0400000, 32'h80000000, 32'h3F400000, 32'h00000000};
        tbl[3] = '{32'h7F000000, 32'h3F800000, 32'h40800000, 32'h3F800000,
                   32'h7F800000, 32'h3F800000, 32'h7F000000, 32'h40800000};
        tbl[4] = '{32'h0D800000, 32'h3F800000, 32'h0D800000, 32'h3F800000,
                   32'h00000000, 32'h3F800000, 32'h0D800000, 32'h0D800000};
        tbl[5] = '{32'h3F800001, 32'h7FC00000, 32'h3F800001, 32'h3F800000,
                   32'h3F800002, 32'h00000000, 32'h3F800001, 32'h00000000};
        for (int i = 0; i < 6; i++) tbl[i].p_ii = neg_ii(tbl[i].p_ii);

        rst = 1'b1;
        bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        bus.a_re = 32'h0; bus.a_im = 32'h0; bus.b_re = 32'h0; bus.b_im = 32'h0;
        tick();
        tick();
        check_int("reset in_ready", int'(bus.in_ready), 1);
        check_int("reset out_valid", int'(bus.out_valid), 0);
        check_int("reset busy", int'(bus.busy), 0);
        check32("reset p_rr", bus.p_rr, 32'h0);
        check32("reset p_ii", bus.p_ii, 32'h0);
        rst = 1'b0;
        tick();

        for (int i = 0; i < 6; i++) begin
            start_txn(tbl[i]);
            check_int("busy in MUL", int'(bus.busy), 1);
            wait_valid(lat);
            check_int("latency", lat, 4);
            check_prod($sformatf("vec%0d", i), tbl[i]);
            drain();
        end

        // Downstream stall: products and handshake state must hold.
        start_txn(tbl[0]);
        wait_valid(lat);
        for (int k = 0; k < 3; k++) begin
            check_int("stall out_valid", int'(bus.out_valid), 1);
            check_int("stall in_ready", int'(bus.in_ready), 0);
            check_prod("stall", tbl[0]);
            tick();
        end
        check_prod("stall end", tbl[0]);
        drain();

        // Reset in the middle of MUL discards everything.
        start_txn(tbl[0]);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_int("midrst out_valid", int'(bus.out_valid), 0);
        check_int("midrst in_ready", int'(bus.in_ready), 1);
        check_int("midrst busy", int'(bus.busy), 0);
        check32("midrst p_rr", bus.p_rr, 32'h0);
        check32("midrst p_ii", bus.p_ii, 32'h0);
        check32("midrst p_ri", bus.p_ri, 32'h0);
        check32("midrst p_ir", bus.p_ir, 32'h0);
        start_txn(tbl[2]);
        wait_valid(lat);
        check_int("post-rst latency", lat, 4);
        check_prod("post-rst", tbl[2]);
        drain();

        // Back-to-back stream with operands changing every cycle.
        bcnt = 0; n_acc = 0; n_done = 0;
        bus.in_valid = 1'b1;
        bus.out_ready = 1'b1;
        for (int c = 0; c < 90; c++) begin
            bus.a_re = rnd_f(); bus.a_im = rnd_f(); bus.b_re = rnd_f(); bus.b_im = rnd_f();
            if (bus.busy) bcnt++;
            if (bus.in_ready) begin
                if (n_acc > 0) check_int("busy cycles per txn", bcnt, 5);
                bcnt = 0;
                exp_q.push_back(model(bus.a_re, bus.a_im, bus.b_re, bus.b_im));
                n_acc++;
            end
            if (bus.out_valid) begin
                if (exp_q.size() == 0) begin
                    check_int("unexpected output", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check_prod($sformatf("stream%0d", n_done), e);
                end
                n_done++;
            end
            tick();
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        check_int("stream completions >= 12", int'(n_done >= 12), 1);

        // One more random transaction through the directed path.
        v = model(rnd_f(), rnd_f(), rnd_f(), rnd_f());
        bus.out_ready = 1'b1;
        wait_valid(lat);
        bus.out_ready = 1'b0;
        tick();
        start_txn(v);
        wait_valid(lat);
        check_int("final latency", lat, 4);
        check_prod("final", v);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
